// File: rtl/simon_param_fifo.sv
// Parameterised synchronous FIFO with standard or first-word-fall-through read, threshold flags and a reset-busy window.
// Occupancy and pointers move on the edge of an accepted request; rejected requests raise a one-cycle overflow/underflow pulse.
module simon_param_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          din,
    input  logic                       wr_en,
    output logic [DATA_W-1:0]          dout,
    input  logic                       rd_en,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     data_count,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       wr_rst_busy,
    output logic                       rd_rst_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [1:0]        busy_cnt_q, busy_cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              busy, is_full, is_empty, wr_acc, rd_acc;

    assign busy     = (busy_cnt_q != 2'd0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign wr_acc   = wr_en && !is_full && !busy;
    assign rd_acc   = rd_en && !is_empty && !busy;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        busy_cnt_d = busy_cnt_q;
        ovf_d      = wr_en && !busy && is_full;
        unf_d      = rd_en && !busy && is_empty;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (busy) busy_cnt_d = busy_cnt_q - 2'd1;
    end

    // Busy counter starts at 3 so it reads non-zero after the release edge and the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            busy_cnt_q <= 2'd3;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            busy_cnt_q <= busy_cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem_q[wr_ptr_q] <= din;
    end

    // FWFT presents the head slot directly; it is driven to zero while empty.
    assign dout         = (FWFT != 0) ? (is_empty ? '0 : mem_q[rd_ptr_q]) : dout_q;
    assign full         = is_full || busy;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= CW'(AFULL_TH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign wr_rst_busy  = busy;
    assign rd_rst_busy  = busy;
endmodule

// File: tb/tb_simon_param_fifo.sv
// Directed bench for simon_param_fifo: one standard-read and one FWFT instance share the same stimulus.
module tb_simon_param_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       wr_en, rd_en;

    logic [7:0] a_dout, b_dout;
    logic [4:0] a_cnt, b_cnt;
    logic a_full, a_empty, a_af, a_ae, a_ovf, a_unf, a_wbusy, a_rbusy;
    logic b_full, b_empty, b_af, b_ae, b_ovf, b_unf, b_wbusy, b_rbusy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simon_param_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .dout(a_dout), .rd_en(rd_en),
        .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .data_count(a_cnt), .overflow(a_ovf), .underflow(a_unf),
        .wr_rst_busy(a_wbusy), .rd_rst_busy(a_rbusy)
    );

    simon_param_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .dout(b_dout), .rd_en(rd_en),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .data_count(b_cnt), .overflow(b_ovf), .underflow(b_unf),
        .wr_rst_busy(b_wbusy), .rd_rst_busy(b_rbusy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
        #2;
        tick(); tick();
        chk("rst_count", a_cnt, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 1);
        chk("rst_afull", a_af, 0);
        chk("rst_aempty", a_ae, 1);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_unf", a_unf, 0);
        chk("rst_wbusy", a_wbusy, 1);
        chk("rst_rbusy", a_rbusy, 1);
        chk("rst_dout0", a_dout, 0);
        chk("rst_dout1", b_dout, 0);

        // Release: busy visible after the release edge and one more, gone after the third.
        rst_n = 1'b1;
        tick(); chk("rel_e0_busy", a_wbusy, 1);
        tick(); chk("rel_e1_busy", a_rbusy, 1); chk("rel_e1_full", a_full, 1);
        tick(); chk("rel_e2_busy", a_wbusy, 0); chk("rel_e2_full", a_full, 0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            din = 8'(i); wr_en = 1'b1;
            tick();
            chk("fill_count", a_cnt, i);
            chk("fill_empty", a_empty, 0);
            chk("fill_afull", a_af, (i >= 14) ? 1 : 0);
            chk("fill_aempty", a_ae, (i <= 2) ? 1 : 0);
            chk("fill_full", a_full, (i == 16) ? 1 : 0);
            chk("fill_fwft_head", b_dout, 8'h01);
        end
        chk("fill_std_dout", a_dout, 0);
        din = 8'h11;
        tick();
        chk("ovf_pulse", a_ovf, 1);
        chk("ovf_count", a_cnt, 16);
        wr_en = 1'b0;
        tick();
        chk("ovf_clear", a_ovf, 0);

        // Drain 16 words
        rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("drain_dout", a_dout, i);
            chk("drain_count", a_cnt, 16 - i);
            if (i < 16) chk("drain_fwft_head", b_dout, i + 1);
        end
        chk("drain_empty", a_empty, 1);
        chk("drain_fwft_empty", b_empty, 1);
        tick();
        chk("unf_pulse", a_unf, 1);
        chk("unf_hold_dout", a_dout, 8'h10);
        rd_en = 1'b0;
        tick();
        chk("unf_clear", a_unf, 0);

        // FWFT single word
        din = 8'hA5; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("fwft_empty_deassert", b_empty, 0);
        chk("fwft_head_a5", b_dout, 8'hA5);
        chk("std_empty_deassert", a_empty, 0);
        tick();
        chk("fwft_head_hold", b_dout, 8'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fwft_pop_empty", b_empty, 1);
        chk("std_read_a5", a_dout, 8'hA5);

        // Simultaneous request at empty: write wins, read rejected
        din = 8'h3C; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("both_empty_count", a_cnt, 1);
        chk("both_empty_unf", a_unf, 1);
        chk("both_empty_ovf", a_ovf, 0);
        for (int i = 1; i <= 15; i++) begin
            din = 8'(8'h40 + i);
            tick();
        end
        chk("refill_count", a_cnt, 16);
        chk("refill_full", a_full, 1);

        // Simultaneous request at full: read wins, write rejected
        din = 8'h99; rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("both_full_ovf", a_ovf, 1);
        chk("both_full_count", a_cnt, 15);
        chk("both_full_dout", a_dout, 8'h3C);
        chk("both_full_fwft", b_dout, 8'h41);

        for (int j = 0; j < 7; j++) begin
            tick();
            chk("to8_dout", a_dout, 8'h41 + j);
        end
        chk("to8_count", a_cnt, 8);

        // 40 cycles of streaming at occupancy 8
        wr_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            din = 8'(8'h80 + k);
            tick();
            chk("stream_count", a_cnt, 8);
            chk("stream_dout", a_dout, (k < 8) ? (8'h48 + k) : (8'h80 + k - 8));
            chk("stream_fwft", b_dout, (k < 7) ? (8'h49 + k) : (8'h80 + k - 7));
        end
        rd_en = 1'b0;
        din = 8'hD0; tick();
        din = 8'hD1; tick();
        wr_en = 1'b0;
        chk("pre_rst_count", a_cnt, 10);

        // Mid-operation reset
        rst_n = 1'b0;
        tick();
        chk("mid_rst_count", a_cnt, 0);
        chk("mid_rst_empty", a_empty, 1);
        chk("mid_rst_busy", a_wbusy, 1);
        rst_n = 1'b1; din = 8'hEE; wr_en = 1'b1;
        tick();
        chk("busy0_count", a_cnt, 0);
        chk("busy0_ovf", a_ovf, 0);
        chk("busy0_flag", a_rbusy, 1);
        tick();
        chk("busy1_count", a_cnt, 0);
        chk("busy1_ovf", a_ovf, 0);
        chk("busy1_flag", a_rbusy, 1);
        wr_en = 1'b0;
        tick();
        chk("busy_drop", a_wbusy, 0);
        chk("busy_drop_count", a_cnt, 0);
        din = 8'h77; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("post_rst_count", a_cnt, 1);
        chk("post_rst_fwft", b_dout, 8'h77);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rst_read", a_dout, 8'h77);
        chk("post_rst_empty", a_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/simon_param_fifo.md
SIMON_PARAM_FIFO -- requirements
Module: simon_param_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, word capacity; power of two, >= 4.
REQ-003 Parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-004 Parameter AFULL_TH, default DEPTH-2, almost-full threshold (1..DEPTH-1).
REQ-005 Parameter AEMPTY_TH, default 2, almost-empty threshold (1..DEPTH-1).
REQ-006 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 Port rst_n, input, 1, synchronous active-low reset.
REQ-008 Port din, input, DATA_W, write data.
REQ-009 Port wr_en, input, 1, write request.
REQ-010 Port dout, output, DATA_W, read data.
REQ-011 Port rd_en, input, 1, read request (FWFT: pop/acknowledge).
REQ-012 Port full / empty, output, 1 each, occupancy flags.
REQ-013 Port almost_full / almost_empty, output, 1 each, threshold flags.
REQ-014 Port data_count, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-015 Port overflow / underflow, output, 1 each, rejected-request pulses.
REQ-016 Port wr_rst_busy / rd_rst_busy, output, 1 each, reset-in-progress indicators.

Function
REQ-017 Write accepted iff wr_en=1, full=0, wr_rst_busy=0; din stored at write pointer on that edge.
REQ-018 Read accepted iff rd_en=1, empty=0, rd_rst_busy=0; read pointer advances on that edge.
REQ-019 Acceptance uses flag values present before the edge; simultaneous read+write when full: read accepted, write rejected; when empty: write accepted, read rejected.
REQ-020 Simultaneous accepted read and write: data_count unchanged, both pointers advance.
REQ-021 Pointers wrap modulo DEPTH; full/empty derived from data_count, never from pointer equality alone.
REQ-022 All outputs are functions of registered state only; no combinational path from wr_en/rd_en/din to any output.
REQ-023 FWFT=0: dout registered, updated with the read word one cycle after accepted read; holds value otherwise.
REQ-024 FWFT=1: dout shows head word whenever empty=0; accepted read presents next word (or sets empty) the following cycle; dout is don't-care while empty=1.
REQ-025 Write-to-empty-deassert latency: empty=0 the cycle after the first accepted write, both modes.
REQ-026 full = (data_count==DEPTH); empty = (data_count==0).
REQ-027 almost_full = (data_count >= AFULL_TH); almost_empty = (data_count <= AEMPTY_TH).
REQ-028 overflow = 1 for exactly one cycle following an edge where wr_en=1 and write rejected due to full; underflow likewise for rd_en=1 rejected due to empty.
REQ-029 Requests during rst_busy are ignored silently: no pointer change, no overflow/underflow pulse.
REQ-030 Stored data is never altered by a rejected write.

Reset
REQ-031 While rst_n=0 at an edge: pointers and data_count cleared, dout=0, empty=1, almost_empty=1, almost_full=0, full=1, overflow=0, underflow=0, wr_rst_busy=1, rd_rst_busy=1.
REQ-032 After the first edge with rst_n=1, busy flags stay 1 for 2 further edges, then drop to 0 together; full drops to 0 with wr_rst_busy.
REQ-033 Reset asserted mid-operation discards all contents on that edge; memory array itself needs no clearing.

Verification (DATA_W=8, DEPTH=16 unless noted)
REQ-034 Reset release, then write 0x01..0x10 -> empty=0 after first write, almost_full=1 at count 14, full=1 at count 16, 17th write gives overflow pulse, data_count stays 16.
REQ-035 FWFT=0: read 16 words -> dout = 0x01..0x10 each one cycle after rd_en; 17th read gives underflow pulse, dout holds 0x10.
REQ-036 FWFT=1: single write 0xA5 to empty FIFO -> next cycle empty=0, dout=0xA5 with no rd_en; rd_en pops, empty=1 next cycle.
REQ-037 At full, wr_en=rd_en=1 same cycle -> read accepted, overflow pulse, data_count=15; at empty, both -> write accepted, underflow pulse, data_count=1.
REQ-038 Continuous simultaneous read/write across 40 cycles at count 8 -> data_count constant 8, pointers wrap, output order matches input order.
REQ-039 rst_n low with count 10 -> next cycle data_count=0, empty=1, busy=1; writes during the two busy cycles ignored, no overflow.
